mem_stage: RTL
==============

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter DMEM_SIZE, default 1024, SHALL give the data-memory size in bytes; valid addresses are 0..DMEM_SIZE-8.
REQ-002 Ports SHALL be as follows (clock and reset first):
- clk  in  1  single clock; all state changes on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- M_bubble  in  1  load a nop into M instead of the execute outputs.
- E_stat, E_icode  in  4 each  execute-stage status and icode.
- e_Cnd  in  1  condition result from execute.
- e_valE, E_valA  in  64 each  ALU result and operand A.
- e_dstE, E_dstM  in  4 each  destination registers.
- M_stat, M_icode, M_dstE, M_dstM  out  4 each  M pipeline register.
- M_Cnd  out  1  M pipeline register.
- M_valE, M_valA  out  64 each  M pipeline register.
- m_valM  out  64  read data.
- m_stat  out  4  resolved status.
- m_busy  out  1  stall request to F/D/E.
- dmem_req, dmem_we  out  1 each  memory request and write enable.
- dmem_addr, dmem_wdata  out  64 each  memory address and write data.
- dmem_rdata  in  64  memory read data.
- dmem_ack  in  1  memory completion.

Function
REQ-003 Status codes SHALL be: AOK=1, HLT=2, ADR=3, INS=4; nop icode=1.
REQ-004 When m_busy=0, the M register SHALL load the execute outputs at posedge, or a nop with M_stat=AOK if M_bubble=1.
REQ-005 When m_busy=1, the M register SHALL hold its value; m_busy overrides M_bubble.
REQ-006 Reads SHALL be icode 5, 9 and 11; writes SHALL be icode 4, 8 and 10; all other icodes are non-memory.
REQ-007 dmem_addr SHALL be M_valA for icode 9 and 11, and M_valE otherwise; dmem_wdata SHALL be M_valA.
REQ-008 The FSM SHALL have three states: IDLE, REQ and DONE.
REQ-009 On the M load edge, the FSM SHALL go to REQ if the loaded op is a memory op with stat AOK and a legal address, and to DONE otherwise.
REQ-010 In REQ, dmem_req=1 and m_busy=1; dmem_we=1 for writes, else 0; addr, wdata and we SHALL stay stable until ack.
REQ-011 In REQ, when dmem_ack=1 at posedge, the FSM SHALL go to DONE, and m_valM SHALL capture dmem_rdata on reads.
REQ-012 In DONE and IDLE, dmem_req=0, dmem_we=0 and m_busy=0.
REQ-013 m_valM SHALL hold its last value for writes and non-memory ops.
REQ-014 Minimum latency SHALL be two cycles for a memory op (zero-wait ack) and one cycle for a non-memory op.
REQ-015 dmem_ack while not in REQ SHALL be ignored.
REQ-016 m_stat SHALL be ADR for an illegal-address memory op with M_stat=AOK, and M_stat otherwise; combinational.
REQ-017 No request SHALL issue when M_stat≠AOK.

Reset
REQ-018 rst_n=0 SHALL immediately set FSM=IDLE, M_icode=1, M_stat=AOK, M_Cnd=0, M_dstE=M_dstM=15, and M_valE=M_valA=m_valM=0.
REQ-019 Assertion of rst_n mid-REQ SHALL drop dmem_req the same instant, with no memory write completed by this block.

Configuration
REQ-020 With DMEM_ADDR_CHECK_EN defined, any address >DMEM_SIZE-8 SHALL be illegal (ADR, no request).
REQ-021 Without DMEM_ADDR_CHECK_EN, all addresses SHALL be legal and ADR SHALL never be generated by this block.

Verification
REQ-022 mrmovq (icode 5), e_valE=0x40, ack in first REQ cycle with rdata=0x1234 -> dmem_req high 1 cycle, m_valM=0x1234, m_busy high 1 cycle.
REQ-023 rmmovq (icode 4), E_valA=0xAB, e_valE=0x10, ack delayed 3 cycles -> m_busy high 3 cycles, then 1 cycle low; dmem_we=1 with addr/wdata stable; M held, next instruction loads after DONE.
REQ-024 popq (icode 11), E_valA=0x80 -> dmem_addr=0x80; opq (icode 6) -> no request, m_busy=0.
REQ-025 With the macro defined and DMEM_SIZE=1024, mrmovq at e_valE=1020 -> no request, m_stat=3; without the macro -> request issued, m_stat=1.
REQ-026 rst_n low during REQ -> dmem_req=0 immediately, M_icode=1; bubble with m_busy=1 -> M unchanged.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: Y86-64 memory stage -- M pipeline register plus a req/ack data-memory FSM.
// Optional feature: define DMEM_ADDR_CHECK_EN to flag addresses above DMEM_SIZE-8 as ADR.
// Ports: clk, rst_n (async, active-low)
//        M_bubble, E_stat, E_icode, e_Cnd, e_valE, E_valA, e_dstE, E_dstM  - execute side
//        M_stat, M_icode, M_Cnd, M_valE, M_valA, M_dstE, M_dstM            - M register
//        m_valM, m_stat, m_busy                                            - stage results / stall
//        dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_rdata, dmem_ack    - memory handshake
module mem_stage #(
    parameter int DMEM_SIZE = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        M_bubble,
    input  logic [3:0]  E_stat,
    input  logic [3:0]  E_icode,
    input  logic        e_Cnd,
    input  logic [63:0] e_valE,
    input  logic [63:0] E_valA,
    input  logic [3:0]  e_dstE,
    input  logic [3:0]  E_dstM,
    output logic [3:0]  M_stat,
    output logic [3:0]  M_icode,
    output logic [3:0]  M_dstE,
    output logic [3:0]  M_dstM,
    output logic        M_Cnd,
    output logic [63:0] M_valE,
    output logic [63:0] M_valA,
    output logic [63:0] m_valM,
    output logic [3:0]  m_stat,
    output logic        m_busy,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [63:0] dmem_addr,
    output logic [63:0] dmem_wdata,
    input  logic [63:0] dmem_rdata,
    input  logic        dmem_ack
);
    localparam logic [3:0] AOK = 4'd1;
    localparam logic [3:0] ADR = 4'd3;
    localparam logic [3:0] NOP = 4'd1;
    localparam logic [3:0] RNONE = 4'd15;
`ifdef DMEM_ADDR_CHECK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif
    localparam logic [63:0] ADDR_MAX = 64'(DMEM_SIZE - 8);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t      state_q, state_d;
    logic [3:0]  stat_q, stat_d, icode_q, icode_d, dste_q, dste_d, dstm_q, dstm_d;
    logic        cnd_q, cnd_d;
    logic [63:0] vale_q, vale_d, vala_q, vala_d, valm_q, valm_d;

    function automatic logic is_rd(input logic [3:0] i);
        return i == 4'd5 || i == 4'd9 || i == 4'd11;
    endfunction

    function automatic logic is_wr(input logic [3:0] i);
        return i == 4'd4 || i == 4'd8 || i == 4'd10;
    endfunction

    // popq and ret address through the old stack pointer carried in valA
    function automatic logic [63:0] addr_of(input logic [3:0] i, input logic [63:0] ve, input logic [63:0] va);
        return (i == 4'd9 || i == 4'd11) ? va : ve;
    endfunction

    function automatic logic legal(input logic [63:0] a);
        return !CHK_EN || a <= ADDR_MAX;
    endfunction

    always_comb begin
        state_d = state_q;
        stat_d  = stat_q;
        icode_d = icode_q;
        cnd_d   = cnd_q;
        dste_d  = dste_q;
        dstm_d  = dstm_q;
        vale_d  = vale_q;
        vala_d  = vala_q;
        valm_d  = valm_q;
        if (state_q == REQ) begin
            if (dmem_ack) begin
                state_d = DONE;
                valm_d  = is_rd(icode_q) ? dmem_rdata : valm_q;
            end
        end else begin
            stat_d  = M_bubble ? AOK : E_stat;
            icode_d = M_bubble ? NOP : E_icode;
            cnd_d   = M_bubble ? 1'b0 : e_Cnd;
            dste_d  = M_bubble ? RNONE : e_dstE;
            dstm_d  = M_bubble ? RNONE : E_dstM;
            vale_d  = M_bubble ? '0 : e_valE;
            vala_d  = M_bubble ? '0 : E_valA;
            // the FSM decision is made on the values being loaded, so a request starts the next cycle
            state_d = (stat_d == AOK && (is_rd(icode_d) || is_wr(icode_d))
                       && legal(addr_of(icode_d, vale_d, vala_d))) ? REQ : DONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            stat_q  <= AOK;
            icode_q <= NOP;
            cnd_q   <= 1'b0;
            dste_q  <= RNONE;
            dstm_q  <= RNONE;
            vale_q  <= '0;
            vala_q  <= '0;
            valm_q  <= '0;
        end else begin
            state_q <= state_d;
            stat_q  <= stat_d;
            icode_q <= icode_d;
            cnd_q   <= cnd_d;
            dste_q  <= dste_d;
            dstm_q  <= dstm_d;
            vale_q  <= vale_d;
            vala_q  <= vala_d;
            valm_q  <= valm_d;
        end
    end

    assign M_stat     = stat_q;
    assign M_icode    = icode_q;
    assign M_Cnd      = cnd_q;
    assign M_dstE     = dste_q;
    assign M_dstM     = dstm_q;
    assign M_valE     = vale_q;
    assign M_valA     = vala_q;
    assign m_valM     = valm_q;
    assign m_busy     = state_q == REQ;
    assign dmem_req   = state_q == REQ;
    assign dmem_we    = state_q == REQ && is_wr(icode_q);
    assign dmem_addr  = addr_of(icode_q, vale_q, vala_q);
    assign dmem_wdata = vala_q;
    assign m_stat     = (stat_q == AOK && (is_rd(icode_q) || is_wr(icode_q)) && !legal(dmem_addr)) ? ADR : stat_q;
endmodule
